// File: rtl/cnt_window_gen.sv
// Free-running counter with a programmable period that drives CH registered window comparators.
// Define CNT_WIN_SYNC_UPDATE_EN to double-buffer window writes so new bounds take effect only at period wrap.
module cnt_window_gen #(
  parameter int WIDTH = 8,
  parameter int CH    = 2,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  output logic [WIDTH-1:0] cnt,
  output logic [CH-1:0]    out,
  output logic             wrap
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_pact;
  logic [CH-1:0]    r_out;
  logic             r_wrap;
  logic             w_wrap;
  logic [CH-1:0]    w_hit;

  assign w_wrap = en && (r_cnt == r_pact);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pact <= '1;
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap;
      if (en) begin
        r_out <= w_hit;
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
      // The period input is sampled only at wrap, so the running period always completes.
      if (w_wrap) r_pact <= period;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_end;
    logic             w_sel;

    // Out-of-range channel numbers match no generated channel and are dropped.
    assign w_sel     = cfg_we && (cfg_ch == CW'(gi));
    assign w_hit[gi] = (r_start <= r_cnt) && (r_cnt <= r_end);

`ifdef CNT_WIN_SYNC_UPDATE_EN
    logic [WIDTH-1:0] r_sh_start;
    logic [WIDTH-1:0] r_sh_end;
    logic             r_pend;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_start    <= WIDTH'(1);
        r_end      <= '0;
        r_sh_start <= WIDTH'(1);
        r_sh_end   <= '0;
        r_pend     <= 1'b0;
      end else begin
        if (w_sel) begin
          r_sh_start <= cfg_start;
          r_sh_end   <= cfg_end;
        end
        if (w_wrap) begin
          r_pend <= 1'b0;
          // A write landing on the wrap edge bypasses the shadow copy.
          if (w_sel) begin
            r_start <= cfg_start;
            r_end   <= cfg_end;
          end else if (r_pend) begin
            r_start <= r_sh_start;
            r_end   <= r_sh_end;
          end
        end else if (w_sel) begin
          r_pend <= 1'b1;
        end
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_start <= WIDTH'(1);
        r_end   <= '0;
      end else if (w_sel) begin
        r_start <= cfg_start;
        r_end   <= cfg_end;
      end
    end
`endif
  end

  assign cnt  = r_cnt;
  assign out  = r_out;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_cnt_window_gen.sv
// Directed bench for cnt_window_gen: vector table for hold/period cases plus hand sequences for windows and reset.
module tb_cnt_window_gen;
  localparam int WIDTH = 8;
  localparam int CH    = 3;
  localparam int CW    = 2;
`ifdef CNT_WIN_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en = 1'b0;
  logic [WIDTH-1:0] period = '0;
  logic             cfg_we = 1'b0;
  logic [CW-1:0]    cfg_ch = '0;
  logic [WIDTH-1:0] cfg_start = '0;
  logic [WIDTH-1:0] cfg_end = '0;
  logic [WIDTH-1:0] cnt;
  logic [CH-1:0]    out;
  logic             wrap;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [7:0] period;
    logic [7:0] exp_cnt;
    logic [2:0] exp_out;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[19];

  cnt_window_gen #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .cnt(cnt), .out(out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int s, input int e);
    cfg_we    = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_start = WIDTH'(s);
    cfg_end   = WIDTH'(e);
    tick;
    cfg_we    = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input int limit);
    int n = 0;
    while (cnt !== WIDTH'(target) && n < limit) begin
      tick;
      n++;
    end
    chk($sformatf("wait_cnt_%0d", target), 32'(cnt), 32'(target));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en     = vecs[i].en;
      period = vecs[i].period;
      tick;
      $display("vec %0d en=%0b period=%0d cnt=%0d out=%b wrap=%0b", i, en, period, cnt, out, wrap);
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end
  endtask

  function automatic logic in_win(input int v, input int s, input int e);
    return (v >= s) && (v <= e);
  endfunction

  initial begin
    int n;
    int hits;
    int prev;
    logic exp0;

    // en hold at cnt=12 inside window 9..14, then resume
    vecs[0]  = '{1'b0, 8'd20, 8'd12, 3'b001, 1'b0};
    vecs[1]  = '{1'b0, 8'd20, 8'd12, 3'b001, 1'b0};
    vecs[2]  = '{1'b0, 8'd20, 8'd12, 3'b001, 1'b0};
    vecs[3]  = '{1'b0, 8'd20, 8'd12, 3'b001, 1'b0};
    vecs[4]  = '{1'b1, 8'd20, 8'd13, 3'b001, 1'b0};
    vecs[5]  = '{1'b1, 8'd20, 8'd14, 3'b001, 1'b0};
    vecs[6]  = '{1'b1, 8'd20, 8'd15, 3'b001, 1'b0};
    vecs[7]  = '{1'b1, 8'd20, 8'd16, 3'b000, 1'b0};
    // from cnt=20 of a 21-cycle period: period=0, then period=5
    vecs[8]  = '{1'b1, 8'd0,  8'd0,  3'b000, 1'b1};
    vecs[9]  = '{1'b1, 8'd0,  8'd0,  3'b000, 1'b1};
    vecs[10] = '{1'b1, 8'd0,  8'd0,  3'b000, 1'b1};
    vecs[11] = '{1'b1, 8'd5,  8'd0,  3'b000, 1'b1};
    vecs[12] = '{1'b1, 8'd5,  8'd1,  3'b000, 1'b0};
    vecs[13] = '{1'b1, 8'd5,  8'd2,  3'b000, 1'b0};
    vecs[14] = '{1'b1, 8'd5,  8'd3,  3'b000, 1'b0};
    vecs[15] = '{1'b1, 8'd5,  8'd4,  3'b000, 1'b0};
    vecs[16] = '{1'b1, 8'd5,  8'd5,  3'b000, 1'b0};
    vecs[17] = '{1'b1, 8'd5,  8'd0,  3'b000, 1'b1};
    vecs[18] = '{1'b1, 8'd5,  8'd1,  3'b000, 1'b0};

    rst    = 1'b1;
    period = 8'd20;
    tick;
    tick;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;

    cfg_write(0, 9, 14);
    cfg_write(1, 7, 3);
    cfg_write(3, 0, 255);
    en = 1'b1;

    n = 0;
    while (wrap !== 1'b1 && n < 300) begin
      tick;
      n++;
    end
    chk("first_wrap", 32'(wrap), 32'd1);

    hits = 0;
    for (int k = 0; k <= 42; k++) begin
      exp0 = (k > 0) && in_win((k - 1) % 21, 9, 14);
      chk($sformatf("a%0d_cnt", k), 32'(cnt), 32'(k % 21));
      chk($sformatf("a%0d_wrap", k), 32'(wrap), 32'((k % 21) == 0));
      chk($sformatf("a%0d_out0", k), 32'(out[0]), 32'(exp0));
      chk($sformatf("a%0d_out21", k), 32'(out[2:1]), 32'd0);
      if (k >= 1 && k <= 21 && out[0] === 1'b1) hits++;
      if (k < 42) tick;
    end
    chk("a_hits", 32'(hits), 32'd6);

    wait_cnt(12, 30);
    run_vecs(0, 7);

    wait_cnt(5, 40);
    cfg_write(0, 2, 4);
    for (int j = 1; j <= 24; j++) begin
      if (j > 1) tick;
      prev = (4 + j) % 21;
      exp0 = (SYNC && j <= 16) ? in_win(prev, 9, 14) : in_win(prev, 2, 4);
      chk($sformatf("d%0d_cnt", j), 32'(cnt), 32'((5 + j) % 21));
      chk($sformatf("d%0d_out0", j), 32'(out[0]), 32'(exp0));
      chk($sformatf("d%0d_out21", j), 32'(out[2:1]), 32'd0);
    end

    wait_cnt(20, 30);
    cfg_write(0, 12, 13);
    for (int m = 1; m <= 22; m++) begin
      if (m > 1) tick;
      exp0 = (m >= 2) && in_win((m - 2) % 21, 12, 13);
      chk($sformatf("t%0d_cnt", m), 32'(cnt), 32'((m - 1) % 21));
      chk($sformatf("t%0d_out0", m), 32'(out[0]), 32'(exp0));
    end

    wait_cnt(20, 30);
    run_vecs(8, 18);

    period = 8'd20;
    cfg_write(0, 9, 14);
    wait_cnt(11, 40);
    chk("f_out0_pre", 32'(out[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("f_rst_cnt", 32'(cnt), 32'd0);
    chk("f_rst_out", 32'(out), 32'd0);
    chk("f_rst_wrap", 32'(wrap), 32'd0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick;
      chk($sformatf("f%0d_cnt", k), 32'(cnt), 32'(k));
      chk($sformatf("f%0d_wrap", k), 32'(wrap), 32'd0);
      chk($sformatf("f%0d_out", k), 32'(out), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_window_gen.md
# cnt_window_gen

Multi-channel, parametrised successor of the single-window counter: one free-running counter with a programmable period drives CH independent window comparators, each producing a registered output that is high for a programmable count range. Channel windows are written through a simple write port, optionally double-buffered so updates take effect only at period wrap. Used as a timing and strobe generator for PWM-style enables and periodic pulse windows.

## Interface
- WIDTH, 8: counter, period and window bound width.
- CH, 2: number of window channels (≥1).
- CW, derived = max(1, $clog2(CH)): channel select width (localparam).

- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; one clock; asynchronous, active-high.
- en  input  1  count enable; low freezes counter and outputs.
- period  input  WIDTH  terminal count P; sampled into active period at each wrap.
- cfg_we  input  1  window write strobe, one cycle.
- cfg_ch  input  CW  channel written.
- cfg_start  input  WIDTH  window first count.
- cfg_end  input  WIDTH  window last count.
- cnt  output  WIDTH  current count.
- out  output  CH  registered window outputs.
- wrap  output  1  registered one-cycle pulse after terminal count.

## Operation
- Counter: counts 0..P_act, then 0; period is P_act+1 cycles. P_act=0 → cnt stays 0, wrap every enabled cycle.
- Wrap condition W = en && cnt==P_act. On W: cnt←0, P_act←period.
- en=0: cnt, out, P_act, wrap hold (wrap forced 0).
- Channel i active bounds S_i, E_i. out[i] next = (S_i ≤ cnt ≤ E_i), unsigned compare on WIDTH bits.
- S_i > E_i: empty window, out[i] stays 0. No wrap-around windows. E_i > P_act: window clipped by wrap.
- cfg_we with cfg_ch ≥ CH: ignored, no state change.
- Reset values: cnt=0, out=0, wrap=0, P_act={WIDTH{1'b1}}, all S_i=1, E_i=0 (empty), pending flags 0.

## Timing
- out[i] at cycle t+1 reflects cnt at cycle t (one-cycle registered latency); window [S,E] yields out high for E−S+1 enabled cycles, delayed one cycle.
- wrap=1 for exactly the cycle after cnt==P_act with en=1.
- period change effective from the period starting after the next wrap; current period completes.
- Reset asserted mid-period: all state to reset values immediately (asynchronous); counting resumes from 0 on first edge after release; P_act remains all-ones until first wrap.

## Configuration
- Macro CNT_WIN_SYNC_UPDATE_EN.
- Defined: cfg writes land in per-channel shadow registers and set pending[i]; on W, every pending channel copies shadow→active and clears pending. Write on the same edge as W is applied at that W (bypass). Multiple writes before wrap: last wins. Outputs never glitch mid-period.
- Undefined: cfg writes update S_i/E_i directly on the write edge; comparison uses new bounds from the next cycle; no shadow/pending registers.

## Test plan
- Reset release, en=1, period=20, ch0 window 9..14, first wrap passed → out[0] high cnt-cycles 10..15 (6 cycles), wrap every 21 cycles, cnt sequence 0..20.
- period=0 → cnt stuck 0, wrap high every cycle; period=5 afterwards → new period only after next wrap, cycle count 6.
- ch1 write start=7, end=3 → out[1] never high; write cfg_ch=CH (out of range) → no channel changes.
- en low for 4 cycles at cnt=12 inside window → cnt, out hold at 12/high, wrap 0; resumes at 13.
- With CNT_WIN_SYNC_UPDATE_EN: rewrite ch0 to 2..4 at cnt=5 → current period unchanged, new window from next period; write coincident with terminal count → applied for next period. Without macro: same write alters out the following cycle.
- rst pulse at cnt=11 with out[0]=1 → cnt=0, out=0, wrap=0 immediately, windows empty.
